note_feeder: RTL and testbench

NOTE_FEEDER -- requirements
Module: note_feeder

---
 rtl/gv_pkg.sv | 27 ++
 rtl/beat_timer.sv | 47 ++++
 rtl/note_feeder.sv | 179 +++++++++++++++++
 tb/tb_note_feeder.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gv_pkg.sv
// Shared types for the game-view blocks: game modes, feeder FSM states and song geometry.
package gv_pkg;

   typedef enum logic [2:0] {
      MODE_IDLE   = 3'd0,
      MODE_DIFF   = 3'd1,
      MODE_PLAY   = 3'd2,
      MODE_PAUSE  = 3'd3,
      MODE_RESULT = 3'd4
   } mode_t;

   typedef enum logic [1:0] {
      IDLE,
      LEADIN,
      PLAY,
      DONE
   } feed_state_t;

   localparam int unsigned SONG_LEN = 32;
   localparam int unsigned PERIOD_W = 23;

   function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] req,
                                                        input logic [PERIOD_W-1:0] floor_val);
      return (req < floor_val) ? floor_val : req;
   endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat period counter: counts 0..period-1 while running and raises a registered one-cycle tick
// on the last count. tick_next_o is the value tick_o will take after the next edge.
module beat_timer
   import gv_pkg::*;
(
   input  logic                clk,
   input  logic                n_rst,
   input  logic                clear_i,
   input  logic                run_i,
   input  logic [PERIOD_W-1:0] period_i,
   output logic                tick_o,
   output logic                tick_next_o
);

   localparam logic [PERIOD_W-1:0] One = PERIOD_W'(1);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else if (tick_q) begin
         // A strobe always finishes its wrap, so a freeze starting on it lands at count 0.
         cnt_d = '0;
      end else if (run_i) begin
         cnt_d  = cnt_q + One;
         tick_d = (cnt_d == period_i - One);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o      = tick_q;
   assign tick_next_o = tick_d;

endmodule

// File: rtl/note_feeder.sv
// Song note feeder: latches two 32-note tracks and a beat period on PLAY, counts in, then plays
// one note per beat on two lanes, with pause/abort handling and a song-complete pulse.
module note_feeder
   import gv_pkg::*;
#(
   parameter int unsigned LEADIN_BEATS = 4,
   parameter int unsigned MIN_PERIOD   = 16
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic [2:0]  mode,
   input  logic [22:0] diff_speed,
   input  logic [31:0] notes1,
   input  logic [31:0] notes2,
   output logic        beat_clk,
   output logic        note_valid,
   output logic        lane1_note,
   output logic        lane2_note,
   output logic [4:0]  beat_idx,
   output logic        song_done
);

   localparam int unsigned         LeadW     = (LEADIN_BEATS > 1) ? $clog2(LEADIN_BEATS) : 1;
   localparam logic [LeadW-1:0]    LeadLast  = LeadW'(LEADIN_BEATS - 1);
   localparam logic [LeadW-1:0]    LeadOne   = LeadW'(1);
   localparam logic [5:0]          IdxEnd    = 6'(SONG_LEN);
   localparam logic [PERIOD_W-1:0] MinPeriod = PERIOD_W'(MIN_PERIOD);

   feed_state_t         state_q, state_d;
   logic [31:0]         trk1_q, trk1_d, trk2_q, trk2_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [LeadW-1:0]    lead_q, lead_d;
   logic [5:0]          idx_q, idx_d;
   logic                armed_q, armed_d;
   logic                beat_q, beat_d;
   logic                valid_q, valid_d;
   logic                lane1_q, lane1_d, lane2_q, lane2_d;
   logic                done_q, done_d;

   logic       tick, tick_next;
   logic       is_play, is_pause, active, abort;
   logic       timer_clear, timer_run;
   logic [4:0] bit_sel;

   beat_timer u_timer (
      .clk         (clk),
      .n_rst       (n_rst),
      .clear_i     (timer_clear),
      .run_i       (timer_run),
      .period_i    (period_q),
      .tick_o      (tick),
      .tick_next_o (tick_next)
   );

   always_comb begin
      is_play     = (mode == MODE_PLAY);
      is_pause    = (mode == MODE_PAUSE);
      active      = (state_q == LEADIN) || (state_q == PLAY);
      abort       = active && !is_play && !is_pause;
      timer_clear = !active || abort;
      timer_run   = active && is_play;
      bit_sel     = 5'd31 - idx_q[4:0];

      state_d  = state_q;
      trk1_d   = trk1_q;
      trk2_d   = trk2_q;
      period_d = period_q;
      lead_d   = lead_q;
      idx_d    = idx_q;
      valid_d  = valid_q;
      lane1_d  = lane1_q;
      lane2_d  = lane2_q;
      done_d   = 1'b0;
      // A start needs mode to have left PLAY first, so reset or a held PLAY never auto-replays.
      armed_d  = is_play ? armed_q : 1'b1;

      case (state_q)
         IDLE: begin
            if (is_play && armed_q) begin
               state_d  = LEADIN;
               trk1_d   = notes1;
               trk2_d   = notes2;
               period_d = clamp_period(diff_speed, MinPeriod);
               lead_d   = '0;
               idx_d    = '0;
               valid_d  = 1'b0;
               lane1_d  = 1'b0;
               lane2_d  = 1'b0;
               armed_d  = 1'b0;
            end
         end
         LEADIN: begin
            if (tick) begin
               if (lead_q == LeadLast) begin
                  state_d = PLAY;
                  lead_d  = '0;
               end else begin
                  lead_d = lead_q + LeadOne;
               end
            end
         end
         PLAY: begin
            if (tick) begin
               if (idx_q == IdxEnd) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  valid_d = 1'b0;
                  lane1_d = 1'b0;
                  lane2_d = 1'b0;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
            if (tick_next && (idx_q != IdxEnd)) begin
               valid_d = 1'b1;
               lane1_d = trk1_q[bit_sel];
               lane2_d = trk2_q[bit_sel];
            end
         end
         DONE: begin
            if (!is_play) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d = IDLE;
         lead_d  = '0;
         idx_d   = '0;
         valid_d = 1'b0;
         lane1_d = 1'b0;
         lane2_d = 1'b0;
         done_d  = 1'b0;
      end

      // The beat after the last note becomes the song-done cycle rather than a strobe.
      beat_d = tick_next && (idx_d != IdxEnd);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         trk1_q   <= '0;
         trk2_q   <= '0;
         period_q <= '0;
         lead_q   <= '0;
         idx_q    <= '0;
         armed_q  <= 1'b0;
         beat_q   <= 1'b0;
         valid_q  <= 1'b0;
         lane1_q  <= 1'b0;
         lane2_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         trk1_q   <= trk1_d;
         trk2_q   <= trk2_d;
         period_q <= period_d;
         lead_q   <= lead_d;
         idx_q    <= idx_d;
         armed_q  <= armed_d;
         beat_q   <= beat_d;
         valid_q  <= valid_d;
         lane1_q  <= lane1_d;
         lane2_q  <= lane2_d;
         done_q   <= done_d;
      end
   end

   assign beat_clk   = beat_q;
   assign note_valid = valid_q;
   assign lane1_note = lane1_q;
   assign lane2_note = lane2_q;
   assign song_done  = done_q;
   assign beat_idx   = (idx_q == IdxEnd) ? 5'd31 : idx_q[4:0];

endmodule

// File: tb/tb_note_feeder.sv
// Directed bench for note_feeder: reset, full song timing, period clamp, pause, abort and
// mid-song reset, each with hand-computed cycle offsets counted from the LEADIN entry edge.
module tb_note_feeder;
   import gv_pkg::*;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic [2:0]  mode = MODE_IDLE;
   logic [22:0] diff_speed = 23'd16;
   logic [31:0] notes1 = 32'hAAAAAAAA;
   logic [31:0] notes2 = 32'hCCCCCCCC;
   logic        beat_clk, note_valid, lane1_note, lane2_note, song_done;
   logic [4:0]  beat_idx;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   note_feeder #(
      .LEADIN_BEATS (4),
      .MIN_PERIOD   (16)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .mode       (mode),
      .diff_speed (diff_speed),
      .notes1     (notes1),
      .notes2     (notes2),
      .beat_clk   (beat_clk),
      .note_valid (note_valid),
      .lane1_note (lane1_note),
      .lane2_note (lane2_note),
      .beat_idx   (beat_idx),
      .song_done  (song_done)
   );

   // Leaves mode=PLAY set at a negedge; the next posedge is entry, the following negedge offset 0.
   task automatic start_song();
      mode = MODE_IDLE;
      repeat (2) @(negedge clk);
      mode = MODE_PLAY;
   endtask

   task automatic test_reset();
      int ns = 0;
      n_rst = 1'b0;
      mode  = MODE_PLAY;
      repeat (3) @(negedge clk);
      checks++;
      if ({beat_clk, note_valid, lane1_note, lane2_note, song_done, beat_idx} !== 10'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=%b",
                  {beat_clk, note_valid, lane1_note, lane2_note, song_done, beat_idx}, 10'd0);
      end
      n_rst = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (beat_clk) ns++;
      end
      checks++;
      if (ns != 0) begin
         failures++;
         $display("FAIL reset_held_play_no_start got=%0d strobes exp=0", ns);
      end
   endtask

   task automatic test_song();
      int         st_off[40];
      logic [7:0] st_val[40];
      int         ns = 0;
      int         nd = 0;
      int         done_off = -1;
      logic       done_beat = 1'b0;
      logic [7:0] mid, post;
      diff_speed = 23'd16;
      notes1 = 32'hAAAAAAAA;
      notes2 = 32'hCCCCCCCC;
      start_song();
      for (int off = 0; off < 700; off++) begin
         @(negedge clk);
         if (beat_clk) begin
            if (ns < 40) begin
               st_off[ns] = off;
               st_val[ns] = {note_valid, lane1_note, lane2_note, beat_idx};
            end
            ns++;
         end
         if (song_done) begin
            nd++;
            done_off  = off;
            done_beat = beat_clk;
         end
         if (off == 85) mid = {note_valid, lane1_note, lane2_note, beat_idx};
         if (off == 600) post = {note_valid, lane1_note, lane2_note, beat_idx};
      end
      checks++;
      if (st_off[0] != 15) begin
         failures++;
         $display("FAIL song_first_strobe got=%0d exp=15", st_off[0]);
      end
      checks++;
      if (st_off[1] != 31) begin
         failures++;
         $display("FAIL song_second_strobe got=%0d exp=31", st_off[1]);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (st_val[i][7] !== 1'b0) begin
            failures++;
            $display("FAIL song_leadin_valid[%0d] got=%b exp=0", i, st_val[i][7]);
         end
      end
      checks++;
      if (st_val[4] !== 8'b111_00000) begin
         failures++;
         $display("FAIL song_strobe5 got=%b exp=%b", st_val[4], 8'b111_00000);
      end
      checks++;
      if (st_val[5] !== 8'b101_00001) begin
         failures++;
         $display("FAIL song_strobe6 got=%b exp=%b", st_val[5], 8'b101_00001);
      end
      checks++;
      if (st_val[6] !== 8'b110_00010) begin
         failures++;
         $display("FAIL song_strobe7 got=%b exp=%b", st_val[6], 8'b110_00010);
      end
      checks++;
      if (mid !== 8'b111_00001) begin
         failures++;
         $display("FAIL song_hold_between got=%b exp=%b", mid, 8'b111_00001);
      end
      checks++;
      if (ns != 36) begin
         failures++;
         $display("FAIL song_strobe_total got=%0d exp=36", ns);
      end
      checks++;
      if (nd != 1) begin
         failures++;
         $display("FAIL song_done_pulses got=%0d exp=1", nd);
      end
      checks++;
      if (done_off != 592) begin
         failures++;
         $display("FAIL song_done_time got=%0d exp=592", done_off);
      end
      checks++;
      if (done_beat !== 1'b0) begin
         failures++;
         $display("FAIL song_done_beat got=%b exp=0", done_beat);
      end
      checks++;
      if (post[7:5] !== 3'b000) begin
         failures++;
         $display("FAIL song_done_outputs got=%b exp=000", post[7:5]);
      end
      mode = MODE_IDLE;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_clamp();
      int ns = 0;
      int s1 = -1;
      int s10 = -1;
      diff_speed = 23'd3;
      start_song();
      for (int off = 0; off < 200; off++) begin
         @(negedge clk);
         if (off == 100) diff_speed = 23'd40;
         if (beat_clk) begin
            ns++;
            if (ns == 1) s1 = off;
            if (ns == 10) s10 = off;
         end
      end
      checks++;
      if (s1 != 15) begin
         failures++;
         $display("FAIL clamp_first_strobe got=%0d exp=15", s1);
      end
      checks++;
      if (s10 != 159) begin
         failures++;
         $display("FAIL clamp_after_change got=%0d exp=159", s10);
      end
      checks++;
      if (ns != 12) begin
         failures++;
         $display("FAIL clamp_strobe_count got=%0d exp=12", ns);
      end
      mode = MODE_IDLE;
      diff_speed = 23'd16;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_pause();
      logic [4:0] idx230 = '0;
      logic [4:0] first_idx = '0;
      logic [4:0] s17_idx = '0;
      logic       b355 = 1'b0;
      int         quiet = 0;
      int         first_after = -1;
      int         s17 = -1;
      int         done_off = -1;
      start_song();
      for (int off = 0; off < 800; off++) begin
         @(negedge clk);
         if (beat_clk) begin
            if (off > 230 && off <= 330) quiet++;
            if (off > 355 && off < 372) quiet++;
            if (off > 330 && first_after < 0) begin
               first_after = off;
               first_idx   = beat_idx;
            end
            if (off > 357 && s17 < 0) begin
               s17     = off;
               s17_idx = beat_idx;
            end
         end
         if (song_done) done_off = off;
         if (off == 230) begin
            idx230 = beat_idx;
            mode   = MODE_PAUSE;
         end
         if (off == 330) mode = MODE_PLAY;
         if (off == 355) begin
            b355 = beat_clk;
            mode = MODE_PAUSE;
         end
         if (off == 357) mode = MODE_PLAY;
      end
      checks++;
      if (idx230 !== 5'd10) begin
         failures++;
         $display("FAIL pause_start_idx got=%0d exp=10", idx230);
      end
      checks++;
      if (quiet != 0) begin
         failures++;
         $display("FAIL pause_no_strobes got=%0d exp=0", quiet);
      end
      checks++;
      if (first_after != 339 || first_idx !== 5'd10) begin
         failures++;
         $display("FAIL pause_resume_strobe got=%0d/%0d exp=339/10", first_after, first_idx);
      end
      checks++;
      if (b355 !== 1'b1) begin
         failures++;
         $display("FAIL pause_on_strobe_seen got=%b exp=1", b355);
      end
      checks++;
      if (s17 != 372 || s17_idx !== 5'd12) begin
         failures++;
         $display("FAIL pause_on_strobe_next got=%0d/%0d exp=372/12", s17, s17_idx);
      end
      checks++;
      if (done_off != 693) begin
         failures++;
         $display("FAIL pause_done_delay got=%0d exp=693", done_off);
      end
      mode = MODE_IDLE;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_abort();
      logic [4:0] idx390 = '0;
      int         noisy = 0;
      int         ns = 0;
      int         s1 = -1;
      int         s5 = -1;
      logic [5:0] v1 = '0;
      logic [7:0] v5 = '0;
      start_song();
      for (int off = 0; off <= 390; off++) begin
         @(negedge clk);
         if (off == 390) begin
            idx390 = beat_idx;
            mode   = MODE_RESULT;
         end
      end
      @(negedge clk);
      checks++;
      if (idx390 !== 5'd20) begin
         failures++;
         $display("FAIL abort_idx got=%0d exp=20", idx390);
      end
      checks++;
      if ({beat_clk, note_valid, lane1_note, lane2_note, song_done, beat_idx} !== 10'd0) begin
         failures++;
         $display("FAIL abort_outputs got=%b exp=%b",
                  {beat_clk, note_valid, lane1_note, lane2_note, song_done, beat_idx}, 10'd0);
      end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (beat_clk || song_done) noisy++;
      end
      checks++;
      if (noisy != 0) begin
         failures++;
         $display("FAIL abort_quiet got=%0d exp=0", noisy);
      end
      mode = MODE_PLAY;
      for (int off = 0; off < 90; off++) begin
         @(negedge clk);
         if (beat_clk) begin
            ns++;
            if (ns == 1) begin
               s1 = off;
               v1 = {note_valid, beat_idx};
            end
            if (ns == 5) begin
               s5 = off;
               v5 = {note_valid, lane1_note, lane2_note, beat_idx};
            end
         end
      end
      checks++;
      if (s1 != 15 || v1 !== 6'd0) begin
         failures++;
         $display("FAIL abort_restart_first got=%0d/%b exp=15/000000", s1, v1);
      end
      checks++;
      if (s5 != 79 || v5 !== 8'b111_00000) begin
         failures++;
         $display("FAIL abort_restart_note got=%0d/%b exp=79/11100000", s5, v5);
      end
      mode = MODE_IDLE;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [5:0] pre = '0;
      int         ns = 0;
      int         s1 = -1;
      logic [4:0] i1 = 5'd31;
      start_song();
      for (int off = 0; off <= 300; off++) begin
         @(negedge clk);
         if (off == 300) pre = {note_valid, beat_idx};
      end
      checks++;
      if (pre !== {1'b1, 5'd14}) begin
         failures++;
         $display("FAIL rstmid_before got=%b exp=%b", pre, {1'b1, 5'd14});
      end
      #2 n_rst = 1'b0;
      #1;
      checks++;
      if ({beat_clk, note_valid, lane1_note, lane2_note, song_done, beat_idx} !== 10'd0) begin
         failures++;
         $display("FAIL rstmid_async_clear got=%b exp=%b",
                  {beat_clk, note_valid, lane1_note, lane2_note, song_done, beat_idx}, 10'd0);
      end
      @(negedge clk);
      n_rst = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (beat_clk) ns++;
      end
      checks++;
      if (ns != 0) begin
         failures++;
         $display("FAIL rstmid_no_strobe got=%0d exp=0", ns);
      end
      start_song();
      for (int off = 0; off < 20; off++) begin
         @(negedge clk);
         if (beat_clk && s1 < 0) begin
            s1 = off;
            i1 = beat_idx;
         end
      end
      checks++;
      if (s1 != 15 || i1 !== 5'd0) begin
         failures++;
         $display("FAIL rstmid_restart got=%0d/%0d exp=15/0", s1, i1);
      end
      mode = MODE_IDLE;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_song();
      test_clamp();
      test_pause();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
